// File: rtl/ser_frame_pkg.sv
// Shared types for the serial frame controller: FSM states, bit-order codes
// and the output buffer entry. SFC_PARITY_EN adds a parity-error flag per entry.
package ser_frame_pkg;

  // Widest payload word the buffer entry can carry; narrower words are zero-padded.
  localparam int unsigned SFC_MAX_LENGTH = 32;

  localparam logic ORDER_LSB_FIRST = 1'b0;
  localparam logic ORDER_MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  typedef struct packed {
    logic [SFC_MAX_LENGTH-1:0] data;
    logic                      first;
    logic                      last;
`ifdef SFC_PARITY_EN
    logic                      perr;
`endif
  } buf_entry_t;

endpackage

// File: rtl/sfc_out_buf.sv
// Two-entry valid/ready output buffer. The head entry and ovalid are flops,
// so ovalid never depends on oready. A push into a full buffer is accepted
// only when the head pops in the same cycle.
module sfc_out_buf
  import ser_frame_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  buf_entry_t push_entry,
  output logic       accept_c,
  input  logic       oready,
  output logic       ovalid,
  output buf_entry_t head
);

  buf_entry_t tail_q;
  logic       tail_v_q;
  logic       pop;

  assign pop      = ovalid & oready;
  assign accept_c = ~tail_v_q | pop;

  // Pop advances the tail into the head; an accepted push fills the first free slot
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      ovalid   <= 1'b0;
      tail_q   <= '0;
      tail_v_q <= 1'b0;
    end else begin
      if (pop) begin
        head     <= tail_q;
        ovalid   <= tail_v_q;
        tail_v_q <= 1'b0;
      end
      if (push && accept_c) begin
        if (!ovalid || (pop && !tail_v_q)) begin
          head   <= push_entry;
          ovalid <= 1'b1;
        end else begin
          tail_q   <= push_entry;
          tail_v_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ser_frame_ctrl.sv
// Frame controller for the serial receive path: hunts for the sync word,
// reads a length word, then assembles payload words into a 2-entry buffer.
// Define SFC_PARITY_EN for a trailing even-parity bit per payload word and
// the operr output. LENGTH must lie in 4..SFC_MAX_LENGTH.
module ser_frame_ctrl
  import ser_frame_pkg::*;
#(
  parameter int unsigned       LENGTH    = 8,
  parameter logic [LENGTH-1:0] SYNC_WORD = LENGTH'(8'hA5),
  parameter int unsigned       MAX_WORDS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              direct,
  input  logic              ivalid,
  input  logic              idata,
  output logic [LENGTH-1:0] odata,
  output logic              ovalid,
  input  logic              oready,
  output logic              ofirst,
  output logic              olast,
`ifdef SFC_PARITY_EN
  output logic              operr,
`endif
  output logic              frame_done,
  output logic              locked,
  output logic              overflow,
  output logic              len_err,
  input  logic              clear_err
);

  localparam int unsigned      CNT_W    = $clog2(LENGTH);
  localparam int unsigned      WL_W     = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

  state_t            state_q, state_d;
  logic [LENGTH-1:0] sr_q, sr_d, sr_shift, push_word;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
  logic [WL_W-1:0]   wl_q, wl_d;
  logic              dir_q, dir_d, first_q, first_d;
  logic              frame_done_d, len_set, ovf_set;
  logic              accept_bit, order, word_end, push, push_last, push_ok_c;
  buf_entry_t        push_entry, head;
`ifdef SFC_PARITY_EN
  logic              par_q, par_d, push_perr;
`endif

  assign accept_bit = enable & ivalid;
  assign order      = (state_q == HUNT) ? direct : dir_q;
  assign word_end   = (cnt_q == CNT_LAST);
  assign cnt_next   = word_end ? '0 : cnt_q + CNT_W'(1);
  assign push_last  = (wl_q == WL_W'(1));

  // Shift the incoming bit into the word per the active bit order
  always_comb begin
    sr_shift = sr_q;
    case (order)
      ORDER_LSB_FIRST: sr_shift = {idata, sr_q[LENGTH-1:1]};
      ORDER_MSB_FIRST: sr_shift = {sr_q[LENGTH-2:0], idata};
    endcase
  end

  // Next-state, counters and error/flag generation
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    wl_d         = wl_q;
    dir_d        = dir_q;
    first_d      = first_q;
    push         = 1'b0;
    push_word    = '0;
    len_set      = 1'b0;
    ovf_set      = 1'b0;
    frame_done_d = 1'b0;
`ifdef SFC_PARITY_EN
    par_d        = par_q;
    push_perr    = 1'b0;
`endif
    if (accept_bit) begin
      case (state_q)
        HUNT: begin
          if (sr_shift == SYNC_WORD) begin
            state_d = LEN;
            sr_d    = '0;
            cnt_d   = '0;
            dir_d   = direct;
          end else begin
            sr_d = sr_shift;
          end
        end
        LEN: begin
          sr_d  = sr_shift;
          cnt_d = cnt_next;
          if (word_end) begin
            if ((sr_shift == '0) || (sr_shift > LENGTH'(MAX_WORDS))) begin
              len_set = 1'b1;
              state_d = HUNT;
            end else begin
              state_d = PAYLOAD;
              wl_d    = WL_W'(sr_shift);
              first_d = 1'b1;
            end
          end
        end
        PAYLOAD: begin
`ifdef SFC_PARITY_EN
          if (par_q) begin
            push      = 1'b1;
            push_word = sr_q;
            push_perr = ^{sr_q, idata};
            par_d     = 1'b0;
          end else begin
            sr_d  = sr_shift;
            cnt_d = cnt_next;
            par_d = word_end;
          end
`else
          sr_d  = sr_shift;
          cnt_d = cnt_next;
          if (word_end) begin
            push      = 1'b1;
            push_word = sr_shift;
          end
`endif
        end
        default: state_d = HUNT;
      endcase
    end
    if (push) begin
      if (!push_ok_c) begin
        ovf_set = 1'b1;
        state_d = HUNT;
      end else begin
        wl_d    = wl_q - WL_W'(1);
        first_d = 1'b0;
        if (push_last) begin
          frame_done_d = 1'b1;
          state_d      = HUNT;
        end
      end
    end
    // Any return to HUNT restarts the bit hunt from a clean word
    if ((state_d == HUNT) && (state_q != HUNT)) begin
      sr_d  = '0;
      cnt_d = '0;
`ifdef SFC_PARITY_EN
      par_d = 1'b0;
`endif
    end
  end

  // Buffer entry for the word being pushed
  always_comb begin
    push_entry       = '0;
    push_entry.data  = SFC_MAX_LENGTH'(push_word);
    push_entry.first = first_q;
    push_entry.last  = push_last;
`ifdef SFC_PARITY_EN
    push_entry.perr  = push_perr;
`endif
  end

  // State and registered outputs; a new error outranks a same-cycle clear
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      cnt_q      <= '0;
      wl_q       <= '0;
      dir_q      <= 1'b0;
      first_q    <= 1'b0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
      len_err    <= 1'b0;
`ifdef SFC_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      wl_q       <= wl_d;
      dir_q      <= dir_d;
      first_q    <= first_d;
      frame_done <= frame_done_d;
      locked     <= (state_d != HUNT);
      overflow   <= ovf_set | (overflow & ~clear_err);
      len_err    <= len_set | (len_err & ~clear_err);
`ifdef SFC_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  sfc_out_buf u_out_buf (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .accept_c   (push_ok_c),
    .oready     (oready),
    .ovalid     (ovalid),
    .head       (head)
  );

  assign odata  = head.data[LENGTH-1:0];
  assign ofirst = head.first;
  assign olast  = head.last;
`ifdef SFC_PARITY_EN
  assign operr  = head.perr;
`endif

  // Padding bits above LENGTH are constant zero
  if (LENGTH < SFC_MAX_LENGTH) begin : g_pad
    logic [SFC_MAX_LENGTH-LENGTH-1:0] unused_hi;
    assign unused_hi = head.data[SFC_MAX_LENGTH-1:LENGTH];
  end

endmodule

// File: tb/tb_ser_frame_ctrl.sv
// Scoreboard bench for ser_frame_ctrl (default build, LENGTH=8).
module tb_ser_frame_ctrl;

  logic       clock = 1'b0;
  logic       reset, enable, direct, ivalid, idata, oready, clear_err;
  logic [7:0] odata;
  logic       ovalid, ofirst, olast, frame_done, locked, overflow, len_err;
`ifdef SFC_PARITY_EN
  logic       operr;
`endif

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clock = ~clock;

  ser_frame_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .direct     (direct),
    .ivalid     (ivalid),
    .idata      (idata),
    .odata      (odata),
    .ovalid     (ovalid),
    .oready     (oready),
    .ofirst     (ofirst),
    .olast      (olast),
`ifdef SFC_PARITY_EN
    .operr      (operr),
`endif
    .frame_done (frame_done),
    .locked     (locked),
    .overflow   (overflow),
    .len_err    (len_err),
    .clear_err  (clear_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pop the scoreboard on every handshake
  always @(negedge clock) begin
    if (frame_done) fd_cnt++;
    if (!reset && ovalid && oready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", odata);
      end else begin
        e = exp_q.pop_front();
        chk("odata", 32'(odata), 32'(e.data));
        chk("ofirst", 32'(ofirst), 32'(e.first));
        chk("olast", 32'(olast), 32'(e.last));
        if (e.last) chk("frame_done_with_last", 32'(frame_done), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ivalid = 1'b1;
    idata  = b;
    tick();
    ivalid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic msb);
    for (int i = 0; i < 8; i++) send_bit(msb ? w[7-i] : w[i]);
  endtask

  task automatic idle(input int n);
    ivalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic expect_word(input logic [7:0] d, input logic f, input logic l);
    exp_t x;
    x.data  = d;
    x.first = f;
    x.last  = l;
    exp_q.push_back(x);
  endtask

  task automatic drain_check(input string tag);
    idle(4);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  logic [7:0] w;

  initial begin
    reset = 1'b1; enable = 1'b1; direct = 1'b0; ivalid = 1'b0;
    idata = 1'b0; oready = 1'b1; clear_err = 1'b0;
    tick(); tick();
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_odata", 32'(odata), 32'd0);
    reset = 1'b0;
    tick();

    // Basic LSB-first frame
    expect_word(8'h11, 1'b1, 1'b0);
    expect_word(8'h22, 1'b0, 1'b0);
    expect_word(8'h33, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0);
    chk("t1_locked", 32'(locked), 32'd1);
    send_word(8'h03, 1'b0);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    chk("t1_unlocked", 32'(locked), 32'd0);
    drain_check("t1");
    chk("t1_fd_cnt", 32'(fd_cnt), 32'd1);

    // MSB-first with junk ahead of sync; direct changes after lock
    direct = 1'b1;
    expect_word(8'h11, 1'b1, 1'b0);
    expect_word(8'h22, 1'b0, 1'b0);
    expect_word(8'h33, 1'b0, 1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t2_hunting", 32'(locked), 32'd0);
    send_word(8'hA5, 1'b1);
    chk("t2_locked", 32'(locked), 32'd1);
    direct = 1'b0;
    send_word(8'h03, 1'b1);
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1);
    send_word(8'h33, 1'b1);
    chk("t2_unlocked", 32'(locked), 32'd0);
    drain_check("t2");
    chk("t2_fd_cnt", 32'(fd_cnt), 32'd2);

    // Length 0, then length 20 with clear_err on the same cycle as the error
    send_word(8'hA5, 1'b0);
    send_word(8'h00, 1'b0);
    chk("t3_len0_err", 32'(len_err), 32'd1);
    chk("t3_len0_unlocked", 32'(locked), 32'd0);
    pulse_clear();
    chk("t3_cleared", 32'(len_err), 32'd0);
    send_word(8'hA5, 1'b0);
    w = 8'h14;
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    clear_err = 1'b1;
    send_bit(w[7]);
    clear_err = 1'b0;
    chk("t3_len20_err_wins", 32'(len_err), 32'd1);
    chk("t3_len20_unlocked", 32'(locked), 32'd0);
    drain_check("t3");
    chk("t3_fd_cnt", 32'(fd_cnt), 32'd2);
    pulse_clear();
    chk("t3_cleared2", 32'(len_err), 32'd0);

    // Consumer stalled: third word overflows and aborts the frame
    oready = 1'b0;
    expect_word(8'h44, 1'b1, 1'b0);
    expect_word(8'h55, 1'b0, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h03, 1'b0);
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b0);
    chk("t4_no_overflow_yet", 32'(overflow), 32'd0);
    send_word(8'h66, 1'b0);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_unlocked", 32'(locked), 32'd0);
    chk("t4_ovalid_held", 32'(ovalid), 32'd1);
    chk("t4_head", 32'(odata), 32'h44);
    chk("t4_fd_cnt", 32'(fd_cnt), 32'd2);
    oready = 1'b1;
    drain_check("t4");
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);
    pulse_clear();
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);

    // enable low for 10 cycles mid word 2 while ivalid toggles
    expect_word(8'h11, 1'b1, 1'b0);
    expect_word(8'h22, 1'b0, 1'b0);
    expect_word(8'h33, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0);
    send_word(8'h03, 1'b0);
    send_word(8'h11, 1'b0);
    w = 8'h22;
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ivalid = (i % 2 == 0);
      idata  = 1'($urandom_range(0, 1));
      tick();
    end
    ivalid = 1'b0;
    enable = 1'b1;
    chk("t5_locked_in_stall", 32'(locked), 32'd1);
    for (int i = 3; i < 8; i++) send_bit(w[i]);
    send_word(8'h33, 1'b0);
    chk("t5_unlocked", 32'(locked), 32'd0);
    drain_check("t5");
    chk("t5_fd_cnt", 32'(fd_cnt), 32'd3);

    // Reset mid-PAYLOAD with one word buffered, then a clean frame
    oready = 1'b0;
    send_word(8'hA5, 1'b0);
    send_word(8'h02, 1'b0);
    send_word(8'h77, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t6_buffered", 32'(ovalid), 32'd1);
    chk("t6_locked", 32'(locked), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_ovalid", 32'(ovalid), 32'd0);
    chk("t6_rst_locked", 32'(locked), 32'd0);
    chk("t6_rst_odata", 32'(odata), 32'd0);
    reset = 1'b0;
    oready = 1'b1;
    tick();
    expect_word(8'h5A, 1'b1, 1'b0);
    expect_word(8'hC3, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0);
    send_word(8'h02, 1'b0);
    send_word(8'h5A, 1'b0);
    send_word(8'hC3, 1'b0);
    drain_check("t6");
    chk("t6_fd_cnt", 32'(fd_cnt), 32'd4);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_len_err", 32'(len_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
